// File: rtl/sixteenby1demux_seq_if.sv
// Bus bundle for the registered 1-to-16 demux: serial input handshake, parallel outputs and frame handshake.
interface sixteenby1demux_seq_if;
   logic        din;
   logic        din_valid;
   logic        din_ready;
   logic [3:0]  s;
   logic        auto_en;
   logic [15:0] y;
   logic [15:0] upd;
   logic        frame_vld;
   logic        frame_ack;
   logic [3:0]  ch;
   logic        par_err;

   modport master (
      output din, din_valid, s, auto_en, frame_ack,
      input  din_ready, y, upd, frame_vld, ch, par_err
   );

   modport slave (
      input  din, din_valid, s, auto_en, frame_ack,
      output din_ready, y, upd, frame_vld, ch, par_err
   );
endinterface

// File: rtl/sixteenby1demux_seq.sv
// Registered 1-to-16 demux with manual channel writes and an auto-scan frame mode.
// Optional macro PARITY_CHK_EN adds an even-parity bit after each auto frame.
module sixteenby1demux_seq #(
   parameter bit HOLD      = 1'b1,
   parameter bit ERR_STICK = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   sixteenby1demux_seq_if.slave bus
);

`ifdef PARITY_CHK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t      r_state;
   state_t      w_next;
   logic        w_ready;
   logic        w_frame_vld;
   logic        w_xfer;
   logic [15:0] r_y;
   logic [15:0] r_upd;
   logic [3:0]  r_ch;
   logic        r_par_err;
   logic [15:0] w_sel_s;
   logic [15:0] w_sel_ch;

   assign w_xfer   = bus.din_valid & w_ready;
   assign w_sel_s  = 16'(1) << bus.s;
   assign w_sel_ch = 16'(1) << r_ch;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; auto_en only matters when a frame can start
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_xfer && bus.auto_en) w_next = SCAN;
`ifdef PARITY_CHK_EN
         SCAN: if (w_xfer && r_ch == 4'd15) w_next = PAR;
         PAR:  if (w_xfer) w_next = DONE;
`else
         SCAN: if (w_xfer && r_ch == 4'd15) w_next = DONE;
`endif
         DONE: if (bus.frame_ack) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs decoded from the state register
   always_comb begin
      w_ready     = 1'b1;
      w_frame_vld = 1'b0;
      if (r_state == DONE) begin
         w_ready     = 1'b0;
         w_frame_vld = 1'b1;
      end
   end

   // Data path: y, upd strobe, scan index and parity flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y       <= '0;
         r_upd     <= '0;
         r_ch      <= '0;
         r_par_err <= 1'b0;
      end else begin
         r_upd <= '0;
         if (w_xfer) begin
            case (r_state)
               IDLE: begin
                  if (bus.auto_en) begin
                     r_y[0] <= bus.din;
                     r_upd  <= 16'h0001;
                     r_ch   <= 4'd1;
                     if (!ERR_STICK) r_par_err <= 1'b0;
                  end else begin
                     if (HOLD) r_y[bus.s] <= bus.din;
                     else      r_y <= bus.din ? w_sel_s : 16'h0000;
                     r_upd <= w_sel_s;
                  end
               end
               SCAN: begin
                  r_y[r_ch] <= bus.din;
                  r_upd     <= w_sel_ch;
                  r_ch      <= r_ch + 4'd1;
               end
`ifdef PARITY_CHK_EN
               PAR: if (bus.din != ^r_y) r_par_err <= 1'b1;
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.din_ready = w_ready;
   assign bus.frame_vld = w_frame_vld;
   assign bus.y         = r_y;
   assign bus.upd       = r_upd;
   assign bus.ch        = r_ch;
   assign bus.par_err   = r_par_err;

endmodule
